alu_mc: RTL

- Parametrised multi-cycle successor to the single-cycle RV32I ALU.
- Executes every base integer op plus the RV32M multiply/divide ops.
- Registered result, valid/ready handshakes on both sides.
- Sits in the execute stage; a busy divide or multiply stalls issue through in_ready.

---
 rtl/alu_mc.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle RV32I/M ALU with valid/ready handshakes
// Optional: ALU_MC_FAST_MUL_EN replaces the iterative multiplier with a combinational one.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [4:0]       op,
    input  logic             m_sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state;
    logic [SHW-1:0]     count;
    logic [2:0]         mop;
    logic               neg_q;
    logic               neg_r;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvs;

    logic [2:0]         f3;
    logic               alt;
    logic               accept;
    logic               a_neg;
    logic               b_neg;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   base_res;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               mul_neg;
    logic               div_signed;
    logic [WIDTH-1:0]   div_a;
    logic [WIDTH-1:0]   div_b;
    logic               div_zero;
    logic               div_ovf;
    logic [WIDTH-1:0]   div_special;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_nx;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   quo_nx;
    logic [WIDTH-1:0]   rem_nx;

    assign f3       = op[3:1];
    assign alt      = op[4];
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign a_neg    = in1[WIDTH-1];
    assign b_neg    = in2[WIDTH-1];
    assign shamt    = in2[SHW-1:0];

    // The alt bit is only meaningful for SUB and SRA; elsewhere the encoding is undefined.
    always_comb begin
        base_res = '0;
        case (f3)
            3'b000:  base_res = (alt && op[0]) ? in1 - in2 : in1 + in2;
            3'b001:  base_res = in1 << shamt;
            3'b010:  base_res[0] = $signed(in1) < $signed(in2);
            3'b011:  base_res[0] = in1 < in2;
            3'b100:  base_res = in1 ^ in2;
            3'b101:  base_res = alt ? $unsigned($signed(in1) >>> shamt) : in1 >> shamt;
            3'b110:  base_res = in1 | in2;
            default: base_res = in1 & in2;
        endcase
        if (alt && f3 != 3'b000 && f3 != 3'b101) begin
            base_res = '0;
        end
    end

    // Multiply and divide run on magnitudes; the sign is restored on the way out.
    assign mul_a   = ((f3 == 3'b001 || f3 == 3'b010) && a_neg) ? -in1 : in1;
    assign mul_b   = (f3 == 3'b001 && b_neg) ? -in2 : in2;
    assign mul_neg = (f3 == 3'b001) ? (a_neg ^ b_neg) : ((f3 == 3'b010) ? a_neg : 1'b0);

    assign div_signed  = ~f3[0];
    assign div_a       = (div_signed && a_neg) ? -in1 : in1;
    assign div_b       = (div_signed && b_neg) ? -in2 : in2;
    assign div_zero    = (in2 == '0);
    assign div_ovf     = div_signed && (in1 == {1'b1, {(WIDTH-1){1'b0}}}) && (in2 == '1);
    assign div_special = div_zero ? (f3[1] ? in1 : '1) : (f3[1] ? '0 : in1);

    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_nx   = {mul_sum, prod[WIDTH-1:1]};
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, dvs});
    assign rem_nx    = div_ge ? (div_shift[WIDTH-1:0] - dvs) : div_shift[WIDTH-1:0];
    assign quo_nx    = {quo[WIDTH-2:0], div_ge};

    function automatic logic [WIDTH-1:0] mul_pick(input logic [2*WIDTH-1:0] p,
                                                  input logic neg, input logic [2:0] sel);
        logic [2*WIDTH-1:0] s;
        s = neg ? -p : p;
        return (sel == 3'b000) ? s[WIDTH-1:0] : s[2*WIDTH-1:WIDTH];
    endfunction

`ifdef ALU_MC_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            count     <= '0;
            mop       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            prod      <= '0;
            mcand     <= '0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mop   <= f3;
                    count <= '0;
                    if (!m_sel) begin
                        out       <= base_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (!f3[2]) begin
`ifdef ALU_MC_FAST_MUL_EN
                        out       <= mul_pick(fast_prod, mul_neg, f3);
                        out_valid <= 1'b1;
                        state     <= DONE;
`else
                        prod  <= {{WIDTH{1'b0}}, mul_b};
                        mcand <= mul_a;
                        neg_q <= mul_neg;
                        state <= MUL;
`endif
                    end else if (div_zero || div_ovf) begin
                        out       <= div_special;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        quo   <= div_a;
                        rem   <= '0;
                        dvs   <= div_b;
                        neg_q <= div_signed && (a_neg ^ b_neg);
                        neg_r <= div_signed && a_neg;
                        state <= DIV;
                    end
                end
                MUL: begin
                    prod  <= prod_nx;
                    count <= count + 1'b1;
                    if (count == '1) begin
                        out       <= mul_pick(prod_nx, neg_q, mop);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DIV: begin
                    quo   <= quo_nx;
                    rem   <= rem_nx;
                    count <= count + 1'b1;
                    if (count == '1) begin
                        if (mop[1]) begin
                            out <= neg_r ? -rem_nx : rem_nx;
                        end else begin
                            out <= neg_q ? -quo_nx : quo_nx;
                        end
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
